// File: rtl/instruction_decode.sv
// -----------------------------------------------------------------------------
// instruction_decode
//
// Decode stage of the MIPS pipeline. Splits the fetched instruction into its
// R/I-type fields, reads the 32x32 register file and registers the operand and
// opcode bundle that execute consumes one cycle after the instruction is accepted.
// It also owns the register file write port driven by writeback, and it stalls
// fetch for one cycle on a load-use hazard.
//
// Ports
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_valid, i_instruction      instruction from fetch
//   o_ready                     decode accepts the instruction this cycle
//   i_wb_en/i_wb_addr/i_wb_data register file write port (writeback)
//   o_valid                     output bundle valid
//   o_data_1, o_data_2          rs value; rt value (R-type) or extended imm
//   o_code                      ALU function code for execute
//   o_rd, o_reg_write           destination register and its write enable
//   o_mem_read, o_mem_write     LW / SW flags
//   o_illegal                   one-cycle pulse on an unsupported opcode
//
// Build option
//   ID_WB_BYPASS_EN : when defined, a writeback to rs/rt in the same cycle
//                     is forwarded into the captured operand (write-through).
//                     When undefined, the pre-write value is read.
// -----------------------------------------------------------------------------
module instruction_decode #(
    parameter int NB_DATA = 32,
    parameter int NB_OP   = 6,
    parameter int NB_REG  = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [31:0]        i_instruction,
    output logic               o_ready,
    input  logic               i_wb_en,
    input  logic [NB_REG-1:0]  i_wb_addr,
    input  logic [NB_DATA-1:0] i_wb_data,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_data_1,
    output logic [NB_DATA-1:0] o_data_2,
    output logic [NB_OP-1:0]   o_code,
    output logic [NB_REG-1:0]  o_rd,
    output logic               o_reg_write,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_illegal
);

    localparam logic [NB_OP-1:0] OP_RTYPE = 6'b000000;
    localparam logic [NB_OP-1:0] OP_ADDI  = 6'b001000;
    localparam logic [NB_OP-1:0] OP_SLTI  = 6'b001010;
    localparam logic [NB_OP-1:0] OP_ANDI  = 6'b001100;
    localparam logic [NB_OP-1:0] OP_ORI   = 6'b001101;
    localparam logic [NB_OP-1:0] OP_LW    = 6'b100011;
    localparam logic [NB_OP-1:0] OP_SW    = 6'b101011;

    localparam logic [NB_OP-1:0] FN_ADD = 6'b100000;
    localparam logic [NB_OP-1:0] FN_SLT = 6'b101010;
    localparam logic [NB_OP-1:0] FN_AND = 6'b100100;
    localparam logic [NB_OP-1:0] FN_OR  = 6'b100101;

    // Instruction fields
    logic [NB_OP-1:0]   opcode_s;
    logic [NB_REG-1:0]  rs_s;
    logic [NB_REG-1:0]  rt_s;
    logic [NB_REG-1:0]  rd_s;
    logic [15:0]        imm_s;
    logic [NB_OP-1:0]   funct_s;
    logic [NB_DATA-1:0] sext_s;
    logic [NB_DATA-1:0] zext_s;

    assign opcode_s = i_instruction[31:26];
    assign rs_s     = i_instruction[25:21];
    assign rt_s     = i_instruction[20:16];
    assign rd_s     = i_instruction[15:11];
    assign imm_s    = i_instruction[15:0];
    assign funct_s  = i_instruction[5:0];
    assign sext_s   = {{(NB_DATA-16){imm_s[15]}}, imm_s};
    assign zext_s   = {{(NB_DATA-16){1'b0}}, imm_s};

    // Register file and output bundle state
    logic [NB_DATA-1:0] rf_q [2**NB_REG];

    logic               valid_q,     valid_d;
    logic [NB_DATA-1:0] data_1_q,    data_1_d;
    logic [NB_DATA-1:0] data_2_q,    data_2_d;
    logic [NB_OP-1:0]   code_q,      code_d;
    logic [NB_REG-1:0]  rd_q,        rd_d;
    logic               reg_write_q, reg_write_d;
    logic               mem_read_q,  mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic               illegal_q,   illegal_d;

    logic               wb_write_s;
    logic [NB_DATA-1:0] rs_val_s;
    logic [NB_DATA-1:0] rt_val_s;
    logic               uses_rt_s;
    logic               hazard_s;
    logic               accept_s;

    assign wb_write_s = i_wb_en && (i_wb_addr != {NB_REG{1'b0}});

    // Register file write port; r0 is never written so it always holds zero
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 2**NB_REG; i++) begin
                rf_q[i] <= {NB_DATA{1'b0}};
            end
        end else if (wb_write_s) begin
            rf_q[i_wb_addr] <= i_wb_data;
        end
    end

    // Combinational operand reads, with optional same-cycle writeback forwarding
    always_comb begin
        rs_val_s = (rs_s == {NB_REG{1'b0}}) ? {NB_DATA{1'b0}} : rf_q[rs_s];
        rt_val_s = (rt_s == {NB_REG{1'b0}}) ? {NB_DATA{1'b0}} : rf_q[rt_s];
`ifdef ID_WB_BYPASS_EN
        rs_val_s = (wb_write_s && (i_wb_addr == rs_s)) ? i_wb_data : rs_val_s;
        rt_val_s = (wb_write_s && (i_wb_addr == rt_s)) ? i_wb_data : rt_val_s;
`endif
    end

    // Load-use hazard: the registered bundle is a load whose target feeds this instruction.
    // Only R-type reads rt as a register operand (SW's rt value is not consumed yet).
    assign uses_rt_s = (opcode_s == OP_RTYPE);
    assign hazard_s  = valid_q && mem_read_q && (rd_q != {NB_REG{1'b0}}) && i_valid &&
                       ((rd_q == rs_s) || (uses_rt_s && (rd_q == rt_s)));
    assign o_ready   = !i_reset && !hazard_s;
    assign accept_s  = i_valid && o_ready;

    // Next output bundle: a zeroed bubble unless an instruction is accepted
    always_comb begin
        valid_d     = 1'b0;
        data_1_d    = {NB_DATA{1'b0}};
        data_2_d    = {NB_DATA{1'b0}};
        code_d      = {NB_OP{1'b0}};
        rd_d        = {NB_REG{1'b0}};
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        illegal_d   = 1'b0;
        if (accept_s) begin
            valid_d  = 1'b1;
            data_1_d = rs_val_s;
            case (opcode_s)
                OP_RTYPE: begin
                    data_2_d = rt_val_s; code_d = funct_s; rd_d = rd_s; reg_write_d = 1'b1;
                end
                OP_ADDI: begin
                    data_2_d = sext_s; code_d = FN_ADD; rd_d = rt_s; reg_write_d = 1'b1;
                end
                OP_SLTI: begin
                    data_2_d = sext_s; code_d = FN_SLT; rd_d = rt_s; reg_write_d = 1'b1;
                end
                OP_ANDI: begin
                    data_2_d = zext_s; code_d = FN_AND; rd_d = rt_s; reg_write_d = 1'b1;
                end
                OP_ORI: begin
                    data_2_d = zext_s; code_d = FN_OR; rd_d = rt_s; reg_write_d = 1'b1;
                end
                OP_LW: begin
                    data_2_d = sext_s; code_d = FN_ADD; rd_d = rt_s; reg_write_d = 1'b1;
                    mem_read_d = 1'b1;
                end
                OP_SW: begin
                    data_2_d = sext_s; code_d = FN_ADD; mem_write_d = 1'b1;
                end
                default: begin
                    // Unsupported opcode: consumed, reported, and turned into a bubble
                    valid_d   = 1'b0;
                    data_1_d  = {NB_DATA{1'b0}};
                    illegal_d = 1'b1;
                end
            endcase
        end else begin
            valid_d = 1'b0;
        end
    end

    // Output bundle register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q     <= 1'b0;
            data_1_q    <= {NB_DATA{1'b0}};
            data_2_q    <= {NB_DATA{1'b0}};
            code_q      <= {NB_OP{1'b0}};
            rd_q        <= {NB_REG{1'b0}};
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            data_1_q    <= data_1_d;
            data_2_q    <= data_2_d;
            code_q      <= code_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            illegal_q   <= illegal_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_data_1    = data_1_q;
    assign o_data_2    = data_2_q;
    assign o_code      = code_q;
    assign o_rd        = rd_q;
    assign o_reg_write = reg_write_q;
    assign o_mem_read  = mem_read_q;
    assign o_mem_write = mem_write_q;
    assign o_illegal   = illegal_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode. The driver computes the expected
// bundle for each cycle from a reference model of the ISA rules and queues it;
// a monitor on the falling edge pops and compares against the registered outputs.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_instruction = 32'd0;
    logic        o_ready;
    logic        i_wb_en = 1'b0;
    logic [4:0]  i_wb_addr = 5'd0;
    logic [31:0] i_wb_data = 32'd0;
    logic        o_valid;
    logic [31:0] o_data_1;
    logic [31:0] o_data_2;
    logic [5:0]  o_code;
    logic [4:0]  o_rd;
    logic        o_reg_write;
    logic        o_mem_read;
    logic        o_mem_write;
    logic        o_illegal;

    always #5 clk = ~clk;

    instruction_decode dut (
        .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_instruction(i_instruction),
        .o_ready(o_ready), .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .o_valid(o_valid), .o_data_1(o_data_1), .o_data_2(o_data_2), .o_code(o_code),
        .o_rd(o_rd), .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
        .o_mem_write(o_mem_write), .o_illegal(o_illegal)
    );

    typedef struct packed {
        logic        v;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [5:0]  code;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        ill;
    } bundle_t;

    bundle_t     exp_q[$];
    bundle_t     prev = '0;
    logic [31:0] mreg [32];
    int          checks = 0;
    int          errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Architectural register read as seen by decode in the current cycle
    function automatic logic [31:0] rdreg(input logic [4:0] a, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
        if (we && wa == a) return wd;
`endif
        return mreg[a];
    endfunction

    function automatic bundle_t model(input logic [31:0] ins, input logic we,
                                      input logic [4:0] wa, input logic [31:0] wd);
        bundle_t     b;
        logic [31:0] sx;
        logic [31:0] zx;
        b  = '0;
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'd0, ins[15:0]};
        b.v  = 1'b1;
        b.d1 = rdreg(ins[25:21], we, wa, wd);
        case (ins[31:26])
            6'h00: begin b.d2 = rdreg(ins[20:16], we, wa, wd); b.code = ins[5:0]; b.rd = ins[15:11]; b.rw = 1'b1; end
            6'h08: begin b.d2 = sx; b.code = 6'b100000; b.rd = ins[20:16]; b.rw = 1'b1; end
            6'h0A: begin b.d2 = sx; b.code = 6'b101010; b.rd = ins[20:16]; b.rw = 1'b1; end
            6'h0C: begin b.d2 = zx; b.code = 6'b100100; b.rd = ins[20:16]; b.rw = 1'b1; end
            6'h0D: begin b.d2 = zx; b.code = 6'b100101; b.rd = ins[20:16]; b.rw = 1'b1; end
            6'h23: begin b.d2 = sx; b.code = 6'b100000; b.rd = ins[20:16]; b.rw = 1'b1; b.mr = 1'b1; end
            6'h2B: begin b.d2 = sx; b.code = 6'b100000; b.mw = 1'b1; end
            default: begin b = '0; b.ill = 1'b1; end
        endcase
        return b;
    endfunction

    // One clock cycle of stimulus; returns whether the instruction was accepted
    task automatic cyc(input logic rst, input logic v, input logic [31:0] ins, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd, output logic acc);
        bundle_t e;
        logic    hz;
        logic    rdy;
        @(negedge clk);
        i_reset = rst; i_valid = v; i_instruction = ins;
        i_wb_en = we; i_wb_addr = wa; i_wb_data = wd;
        #1;
        hz  = prev.v && prev.mr && (prev.rd != 5'd0) && v &&
              ((prev.rd == ins[25:21]) || ((ins[31:26] == 6'd0) && (prev.rd == ins[20:16])));
        rdy = !rst && !hz;
        chk("o_ready", {31'd0, o_ready}, {31'd0, rdy});
        acc = v && rdy;
        if (rst) begin
            e = '0;
            for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        end else begin
            e = acc ? model(ins, we, wa, wd) : '0;
            if (we && wa != 5'd0) mreg[wa] = wd;
        end
        exp_q.push_back(e);
        prev = e;
    endtask

    // Present an instruction until accepted (fetch holds it during a stall)
    task automatic issue(input logic [31:0] ins, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 3 && !acc; t++) cyc(1'b0, 1'b1, ins, we, wa, wd, acc);
        chk("issue_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic idle(input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic acc;
        cyc(1'b0, 1'b0, 32'd0, we, wa, wd, acc);
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [8];
        logic [5:0] op;
        ops = '{6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h3F};
        op  = ops[$urandom_range(0, 7)];
        if (op == 6'h3F) op = 6'($urandom_range(0, 63));
        return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
    endfunction

    // Monitor: one expected bundle per elapsed clock edge
    always @(negedge clk) begin
        bundle_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("o_valid",     {31'd0, o_valid},     {31'd0, e.v});
            chk("o_data_1",    o_data_1,             e.d1);
            chk("o_data_2",    o_data_2,             e.d2);
            chk("o_code",      {26'd0, o_code},      {26'd0, e.code});
            chk("o_rd",        {27'd0, o_rd},        {27'd0, e.rd});
            chk("o_reg_write", {31'd0, o_reg_write}, {31'd0, e.rw});
            chk("o_mem_read",  {31'd0, o_mem_read},  {31'd0, e.mr});
            chk("o_mem_write", {31'd0, o_mem_write}, {31'd0, e.mw});
            chk("o_illegal",   {31'd0, o_illegal},   {31'd0, e.ill});
        end
    end

    initial begin
        logic        acc;
        logic        have;
        logic        v;
        logic [31:0] pend;
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;

        // Reset held two cycles, then r5 reads zero
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
        issue(rtype(5'd5, 5'd5, 5'd8, 6'b100000), 1'b0, 5'd0, 32'd0);

        // Writebacks then ADD r4,r1,r2
        idle(1'b1, 5'd1, 32'd1);
        idle(1'b1, 5'd2, 32'd2);
        issue(rtype(5'd1, 5'd2, 5'd4, 6'b100000), 1'b0, 5'd0, 32'd0);

        // Immediates: ADDI r3,r1,-1 ; ORI r5,r0,0x8000 ; ANDI ; SLTI ; SW
        issue(itype(6'h08, 5'd1, 5'd3, 16'hFFFF), 1'b0, 5'd0, 32'd0);
        issue(itype(6'h0D, 5'd0, 5'd5, 16'h8000), 1'b0, 5'd0, 32'd0);
        issue(itype(6'h0C, 5'd2, 5'd9, 16'hF00F), 1'b0, 5'd0, 32'd0);
        issue(itype(6'h0A, 5'd1, 5'd9, 16'h8001), 1'b0, 5'd0, 32'd0);
        issue(itype(6'h2B, 5'd1, 5'd2, 16'h0004), 1'b0, 5'd0, 32'd0);

        // Load-use stall: LW r6,0(r1) ; ADD r7,r6,r2 (one stall cycle, writeback during stall)
        issue(itype(6'h23, 5'd1, 5'd6, 16'h0000), 1'b0, 5'd0, 32'd0);
        issue(rtype(5'd6, 5'd2, 5'd7, 6'b100000), 1'b1, 5'd6, 32'h0000_0066);
        // rt dependency for R-type stalls; SW's rt does not
        issue(itype(6'h23, 5'd1, 5'd6, 16'h0000), 1'b0, 5'd0, 32'd0);
        issue(rtype(5'd2, 5'd6, 5'd7, 6'b100010), 1'b0, 5'd0, 32'd0);
        issue(itype(6'h23, 5'd1, 5'd6, 16'h0000), 1'b0, 5'd0, 32'd0);
        issue(itype(6'h2B, 5'd1, 5'd6, 16'h0008), 1'b0, 5'd0, 32'd0);
        // Dependency through r0: no stall
        issue(itype(6'h23, 5'd1, 5'd0, 16'h0000), 1'b0, 5'd0, 32'd0);
        issue(rtype(5'd0, 5'd0, 5'd7, 6'b100000), 1'b0, 5'd0, 32'd0);

        // Same-cycle writeback and read of r1; then a write to r0 is ignored
        issue(rtype(5'd1, 5'd2, 5'd9, 6'b100000), 1'b1, 5'd1, 32'hA5A5_A5A5);
        issue(rtype(5'd1, 5'd0, 5'd9, 6'b100000), 1'b1, 5'd0, 32'hDEAD_BEEF);
        issue(rtype(5'd0, 5'd1, 5'd9, 6'b100000), 1'b0, 5'd0, 32'd0);

        // Illegal opcode
        issue(itype(6'h3F, 5'd1, 5'd2, 16'h1234), 1'b0, 5'd0, 32'd0);
        idle(1'b0, 5'd0, 32'd0);

        // Reset during a stall cancels it
        issue(itype(6'h23, 5'd1, 5'd6, 16'h0000), 1'b0, 5'd0, 32'd0);
        cyc(1'b0, 1'b1, rtype(5'd6, 5'd2, 5'd7, 6'b100000), 1'b0, 5'd0, 32'd0, acc);
        cyc(1'b1, 1'b1, rtype(5'd6, 5'd2, 5'd7, 6'b100000), 1'b0, 5'd0, 32'd0, acc);
        cyc(1'b0, 1'b1, rtype(5'd6, 5'd2, 5'd7, 6'b100000), 1'b0, 5'd0, 32'd0, acc);

        // Randomized traffic with concurrent writebacks and occasional resets
        have = 1'b0;
        pend = 32'd0;
        for (int i = 0; i < 600; i++) begin
            logic rst;
            if (!have) pend = rand_instr();
            v   = have ? 1'b1 : ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 149) == 0);
            cyc(rst, v, pend, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, acc);
            have = v && !acc && !rst;
        end

        idle(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
